// File: rtl/hs_cmd_arb.sv
// hs_cmd_arb: round-robin merge of NUM_REQ valid/ready command streams into one registered stage; HS_CMD_ARB_CNT_EN adds wr_cnt/rd_cnt.
module hs_cmd_arb #(
  parameter int DATA_WD = 4,
  parameter int ADDR_WD = 4,
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_cmd,
  input  logic [NUM_REQ*ADDR_WD-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WD-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       m_valid,
  output logic                       m_cmd,
  output logic [ADDR_WD-1:0]         m_addr,
  output logic [DATA_WD-1:0]         m_data,
`ifdef HS_CMD_ARB_CNT_EN
  output logic [15:0]                wr_cnt,
  output logic [15:0]                rd_cnt,
`endif
  input  logic                       m_ready
);
  localparam int PTR_WD = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [PTR_WD-1:0]  rr_ptr, lo_idx, hi_idx, gidx, nxt_ptr;
  logic               hi_found, load, fire, sel_cmd;
  logic [ADDR_WD-1:0] sel_addr;
  logic [DATA_WD-1:0] sel_data;
  // hi_idx: first requester at/after rr_ptr; lo_idx: first overall (wrap case)
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    hi_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) lo_idx = PTR_WD'(i);
      if (req_valid[i] && i >= int'(rr_ptr)) begin
        hi_idx = PTR_WD'(i);
        hi_found = 1'b1;
      end
    end
    gidx = hi_found ? hi_idx : lo_idx;
    sel_cmd = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == PTR_WD'(i)) begin
        sel_cmd = req_cmd[i];
        sel_addr = req_addr[i*ADDR_WD +: ADDR_WD];
        sel_data = req_data[i*DATA_WD +: DATA_WD];
      end
    end
  end
  assign load      = ~m_valid | m_ready;
  assign fire      = rstn & load & (|req_valid);
  assign req_ready = fire ? NUM_REQ'(1) << gidx : '0;
  assign nxt_ptr   = gidx == PTR_WD'(NUM_REQ - 1) ? '0 : gidx + 1'b1;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_cmd   <= 1'b0;
      m_addr  <= '0;
      m_data  <= '0;
      rr_ptr  <= '0;
    end else if (load) begin
      m_valid <= fire;
      if (fire) begin
        m_cmd  <= sel_cmd;
        m_addr <= sel_addr;
        m_data <= sel_data;
        rr_ptr <= nxt_ptr;
      end
    end
  end
`ifdef HS_CMD_ARB_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else if (m_valid && m_ready) begin
      if (m_cmd && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
      if (!m_cmd && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hs_cmd_arb.sv
// tb_hs_cmd_arb: directed scoreboard bench for hs_cmd_arb (counter checks when HS_CMD_ARB_CNT_EN is defined).
module tb_hs_cmd_arb;
  localparam int DW = 4, AW = 4, N = 4;
  logic clk = 1'b0, rstn = 1'b0, m_ready = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N-1:0] req_cmd = 4'b0110;
  logic [N*AW-1:0] req_addr = {4'h4, 4'h3, 4'h2, 4'h1};
  logic [N*DW-1:0] req_data = {4'hC, 4'hA, 4'h6, 4'h5};
  logic m_valid, m_cmd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
`ifdef HS_CMD_ARB_CNT_EN
  logic [15:0] wr_cnt, rd_cnt;
`endif
  // expected {cmd,addr,data} per requester
  logic [8:0] exp_t [N] = '{9'h015, 9'h126, 9'h13A, 9'h04C};
  logic [8:0] q [$];
  int checks = 0, failures = 0;

  hs_cmd_arb #(.DATA_WD(DW), .ADDR_WD(AW), .NUM_REQ(N)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .m_valid(m_valid), .m_cmd(m_cmd), .m_addr(m_addr), .m_data(m_data),
`ifdef HS_CMD_ARB_CNT_EN
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt),
`endif
    .m_ready(m_ready));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic r, input int g, input bit push = 1'b1);
    @(posedge clk);
    #1;
    req_valid = v;
    m_ready = r;
    #1;
    chk("req_ready", 32'(req_ready), g < 0 ? 32'd0 : 32'd1 << g);
    if (g >= 0 && push) q.push_back(exp_t[g]);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    req_valid = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rstn && m_valid && m_ready) begin
      if (q.size() == 0) chk("unexpected_output", {23'd0, m_cmd, m_addr, m_data}, 32'h1FF);
      else chk("output_cmd", {23'd0, m_cmd, m_addr, m_data}, {23'd0, q.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    #1;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_cmd", 32'(m_cmd), 0);
    chk("rst_m_addr", 32'(m_addr), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_rr_ptr", 32'(dut.rr_ptr), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    // single requester, then idle bubble
    drive(4'b0100, 1, 2);
    drive(4'b0000, 1, -1);
    chk("t1_rr_ptr", 32'(dut.rr_ptr), 3);
    drive(4'b0000, 1, -1);
    chk("t1_idle_m_valid", 32'(m_valid), 0);
    // all requesting from reset: full-rate rotation
    do_reset();
    drive(4'b1111, 1, 0);
    drive(4'b1111, 1, 1);
    chk("t2_m_valid", 32'(m_valid), 1);
    drive(4'b1111, 1, 2);
    chk("t2_m_valid", 32'(m_valid), 1);
    drive(4'b1111, 1, 3);
    chk("t2_m_valid", 32'(m_valid), 1);
    drive(4'b1111, 1, 0);
    chk("t2_m_valid", 32'(m_valid), 1);
    drive(4'b0000, 1, -1);
    chk("t2_rr_ptr", 32'(dut.rr_ptr), 1);
    // backpressure
    drive(4'b0011, 1, 1);
    for (int k = 0; k < 3; k++) begin
      drive(4'b0011, 0, -1);
      chk("t3_stall_m_valid", 32'(m_valid), 1);
      chk("t3_stall_m_addr", 32'(m_addr), 2);
      chk("t3_stall_m_data", 32'(m_data), 6);
    end
    drive(4'b0011, 1, 0);
    // wrap from rr_ptr=3
    drive(4'b0100, 1, 2);
    drive(4'b0001, 1, 0);
    chk("t4_rr_ptr_pre", 32'(dut.rr_ptr), 3);
    drive(4'b0000, 1, -1);
    chk("t4_rr_ptr", 32'(dut.rr_ptr), 1);
    drive(4'b0000, 1, -1);
    chk("t4_idle_m_valid", 32'(m_valid), 0);
    // reset mid-transfer discards the pending command
    drive(4'b1000, 1, 3, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    req_valid = 4'b1010;
    #1;
    chk("t5_m_valid", 32'(m_valid), 0);
    chk("t5_m_addr", 32'(m_addr), 0);
    chk("t5_m_data", 32'(m_data), 0);
    chk("t5_m_cmd", 32'(m_cmd), 0);
    chk("t5_rr_ptr", 32'(dut.rr_ptr), 0);
    chk("t5_ready_in_reset", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    chk("t5_first_grant", 32'(req_ready), 32'b0010);
    q.push_back(exp_t[1]);
    drive(4'b0000, 1, -1);
    drive(4'b0000, 1, -1);
`ifdef HS_CMD_ARB_CNT_EN
    do_reset();
    drive(4'b0010, 1, 1);
    drive(4'b0100, 1, 2);
    drive(4'b0010, 1, 1);
    drive(4'b0001, 1, 0);
    drive(4'b1000, 1, 3);
    drive(4'b0000, 1, -1);
    drive(4'b0000, 1, -1);
    chk("t6_wr_cnt", 32'(wr_cnt), 3);
    chk("t6_rd_cnt", 32'(rd_cnt), 2);
    @(posedge clk);
    #1;
    force dut.wr_cnt = 16'hFFFF;
    #1;
    release dut.wr_cnt;
    drive(4'b0010, 1, 1);
    drive(4'b0000, 1, -1);
    drive(4'b0000, 1, -1);
    chk("t6_wr_sat", 32'(wr_cnt), 32'hFFFF);
`endif
    chk("queue_drained", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
